trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 39 +++
 rtl/trap_ctrl_if.sv | 26 ++
 rtl/trap_timer.sv | 30 +++
 rtl/trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller.
// FSM states, CSR addresses, cause codes and mstatus bit positions.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        JUMP
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'b00,
        REQ_ECALL = 2'b01,
        REQ_MRET  = 2'b10,
        REQ_RSVD  = 2'b11
    } req_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_ECALL,
        KIND_MRET,
        KIND_IRQ
    } kind_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_TIMER_CODE = 7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap request handshake plus the CSR write port and redirect bundle.
// master = requester side (id/ctrl), slave = trap controller.
interface trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic [1:0]      trap_req_i;
    logic [XLEN-1:0] trap_pc_i;
    logic            trap_ack_o;
    logic            csr_wen_o;
    logic [11:0]     csr_waddr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            jump_en_o;
    logic [XLEN-1:0] jump_addr_o;

    modport master (
        output trap_req_i, trap_pc_i,
        input  trap_ack_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
        input  jump_en_o, jump_addr_o
    );

    modport slave (
        input  trap_req_i, trap_pc_i,
        output trap_ack_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
        output jump_en_o, jump_addr_o
    );
endinterface

// File: rtl/trap_timer.sv
// Machine timer: free-running mtime, loadable mtimecmp, unsigned pending.
// Only instantiated when TRAP_CTRL_TIMER_INTR_EN is defined.
module trap_timer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmp_we,
    input  logic [XLEN-1:0] cmp_wdata,
    output logic [XLEN-1:0] mtime,
    output logic            pending
);

    logic [XLEN-1:0] mtimecmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            mtime <= mtime + XLEN'(1);
            if (cmp_we) begin
                mtimecmp <= cmp_wdata;
            end
        end
    end

    assign pending = (mtime >= mtimecmp);

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: ecall/mret/timer-interrupt entry and return sequencing.
// Optional timer source enabled by macro TRAP_CTRL_TIMER_INTR_EN.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    trap_ctrl_if.slave      bus,
    input  logic            pipe_idle_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] a7_i,
    output logic            stall_o
`ifdef TRAP_CTRL_TIMER_INTR_EN
    ,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            mtimecmp_we_i,
    input  logic [XLEN-1:0] mtimecmp_wdata_i,
    output logic [XLEN-1:0] mtime_o
`endif
);

    localparam logic [XLEN-1:0] IRQ_CAUSE =
        {1'b1, (XLEN-1)'(CAUSE_TIMER_CODE)};

    state_t          state;
    kind_t           kind;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;

    kind_t           take_kind;
    logic [XLEN-1:0] take_pc;
    logic [XLEN-1:0] take_cause;
    logic [XLEN-1:0] irq_pc;
    logic            pending;
    logic            idle;
    logic            irq_take;

`ifdef TRAP_CTRL_TIMER_INTR_EN
    trap_timer #(.XLEN(XLEN)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cmp_we    (mtimecmp_we_i),
        .cmp_wdata (mtimecmp_wdata_i),
        .mtime     (mtime_o),
        .pending   (pending)
    );
    assign irq_pc = irq_pc_i;
`else
    assign pending = 1'b0;
    assign irq_pc  = '0;
`endif

    function automatic logic [XLEN-1:0] enter_status(
        input logic [XLEN-1:0] s
    );
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] leave_status(
        input logic [XLEN-1:0] s
    );
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        return r;
    endfunction

    assign idle     = (state == IDLE);
    assign irq_take = pending && mstatus_i[MSTATUS_MIE];

    // An enabled timer interrupt wins over a same-cycle ecall/mret.
    always_comb begin
        take_kind  = KIND_NONE;
        take_pc    = bus.trap_pc_i;
        take_cause = '0;
        if (irq_take) begin
            take_kind  = KIND_IRQ;
            take_pc    = irq_pc;
            take_cause = IRQ_CAUSE;
        end else if (bus.trap_req_i == REQ_ECALL) begin
            take_kind  = KIND_ECALL;
            take_cause = a7_i;
        end else if (bus.trap_req_i == REQ_MRET) begin
            take_kind = KIND_MRET;
        end
    end

    assign bus.trap_ack_o = !rst && idle &&
        ((take_kind == KIND_ECALL) || (take_kind == KIND_MRET));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            kind            <= KIND_NONE;
            pc_q            <= '0;
            cause_q         <= '0;
            stall_o         <= 1'b0;
            bus.csr_wen_o   <= 1'b0;
            bus.csr_waddr_o <= '0;
            bus.csr_wdata_o <= '0;
            bus.jump_en_o   <= 1'b0;
            bus.jump_addr_o <= '0;
        end else begin
            bus.csr_wen_o   <= 1'b0;
            bus.csr_waddr_o <= '0;
            bus.csr_wdata_o <= '0;
            bus.jump_en_o   <= 1'b0;
            bus.jump_addr_o <= '0;
            unique case (state)
                IDLE: begin
                    if (take_kind != KIND_NONE) begin
                        state   <= DRAIN;
                        kind    <= take_kind;
                        pc_q    <= take_pc;
                        cause_q <= take_cause;
                        stall_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (pipe_idle_i) begin
                        bus.csr_wen_o <= 1'b1;
                        if (kind == KIND_MRET) begin
                            state           <= W_MSTATUS;
                            bus.csr_waddr_o <= CSR_MSTATUS;
                            bus.csr_wdata_o <= leave_status(mstatus_i);
                        end else begin
                            state           <= W_MEPC;
                            bus.csr_waddr_o <= CSR_MEPC;
                            bus.csr_wdata_o <= pc_q;
                        end
                    end
                end
                W_MEPC: begin
                    state           <= W_MCAUSE;
                    bus.csr_wen_o   <= 1'b1;
                    bus.csr_waddr_o <= CSR_MCAUSE;
                    bus.csr_wdata_o <= cause_q;
                end
                W_MCAUSE: begin
                    state           <= W_MSTATUS;
                    bus.csr_wen_o   <= 1'b1;
                    bus.csr_waddr_o <= CSR_MSTATUS;
                    bus.csr_wdata_o <= enter_status(mstatus_i);
                end
                W_MSTATUS: begin
                    state           <= JUMP;
                    bus.jump_en_o   <= 1'b1;
                    bus.jump_addr_o <= (kind == KIND_MRET) ? mepc_i : mtvec_i;
                end
                JUMP: begin
                    state   <= IDLE;
                    stall_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: per-cycle output trace vs a transaction model.
// Timer scenario runs only when TRAP_CTRL_TIMER_INTR_EN is defined.
module tb_trap_ctrl;

    localparam int XLEN = 64;
    localparam int N    = 1024;

    typedef struct packed {
        logic        ack;
        logic        stall;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        jen;
        logic [63:0] jaddr;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_idle;
    logic [63:0] mtvec, mepc, mstatus, a7;
    logic        stall;

    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef TRAP_CTRL_TIMER_INTR_EN
    logic [63:0] irq_pc, tcmp_wdata, mtime;
    logic        tcmp_we;
`endif

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pipe_idle_i (pipe_idle),
        .mtvec_i     (mtvec),
        .mepc_i      (mepc),
        .mstatus_i   (mstatus),
        .a7_i        (a7),
        .stall_o     (stall)
`ifdef TRAP_CTRL_TIMER_INTR_EN
        ,
        .irq_pc_i         (irq_pc),
        .mtimecmp_we_i    (tcmp_we),
        .mtimecmp_wdata_i (tcmp_wdata),
        .mtime_o          (mtime)
`endif
    );

    logic [1:0]  s_req   [N];
    logic [63:0] s_pc    [N];
    logic [63:0] s_a7    [N];
    logic [63:0] s_mtvec [N];
    logic [63:0] s_mepc  [N];
    logic [63:0] s_mst   [N];
    logic        s_idle  [N];
    out_t        e_vec   [N];

    int n_cmp = 0;
    int n_bad = 0;
    int free_at;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference mstatus updates, written as plain bit arithmetic.
    function automatic logic [63:0] enter_model(input logic [63:0] s);
        return (s & ~64'h1888) | 64'h1800 | (((s >> 3) & 64'h1) << 7);
    endfunction

    function automatic logic [63:0] leave_model(input logic [63:0] s);
        return (s & ~64'h1888) | 64'h80 | (((s >> 7) & 64'h1) << 3);
    endfunction

    function automatic out_t obs();
        return {bus.trap_ack_o, stall, bus.csr_wen_o, bus.csr_waddr_o,
                bus.csr_wdata_o, bus.jump_en_o, bus.jump_addr_o};
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            s_req[i]   = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            s_pc[i]    = rnd64();
            s_a7[i]    = rnd64();
            s_mtvec[i] = rnd64();
            s_mepc[i]  = rnd64();
            s_mst[i]   = rnd64();
            s_idle[i]  = 1'($urandom_range(0, 1));
            e_vec[i]   = '0;
        end
        free_at = 0;
    endtask

    // Transaction model: request presented at r, accepted when free,
    // d cycles of pipe_idle low, then the architectural write/jump trace.
    task automatic add_txn(input int r, input logic [1:0] kind,
                           input logic [63:0] pc, input logic [63:0] a7v,
                           input logic [63:0] tv, input logic [63:0] ev,
                           input logic [63:0] sv, input int d,
                           output int t);
        int j;
        t = (r > free_at) ? r : free_at;
        for (int c = r; c <= t; c++) begin
            s_req[c] = kind;
            s_pc[c]  = pc;
            s_a7[c]  = a7v;
        end
        for (int c = t; c < N; c++) begin
            s_mtvec[c] = tv;
            s_mepc[c]  = ev;
            s_mst[c]   = sv;
        end
        for (int c = t + 1; c <= t + d; c++) s_idle[c] = 1'b0;
        s_idle[t+d+1] = 1'b1;
        e_vec[t].ack = 1'b1;
        if (kind == 2'b01) begin
            e_vec[t+d+2].wen   = 1'b1;
            e_vec[t+d+2].waddr = 12'h341;
            e_vec[t+d+2].wdata = pc;
            e_vec[t+d+3].wen   = 1'b1;
            e_vec[t+d+3].waddr = 12'h342;
            e_vec[t+d+3].wdata = a7v;
            e_vec[t+d+4].wen   = 1'b1;
            e_vec[t+d+4].waddr = 12'h300;
            e_vec[t+d+4].wdata = enter_model(sv);
            j = t + d + 5;
            e_vec[j].jaddr = tv;
        end else begin
            e_vec[t+d+2].wen   = 1'b1;
            e_vec[t+d+2].waddr = 12'h300;
            e_vec[t+d+2].wdata = leave_model(sv);
            j = t + d + 3;
            e_vec[j].jaddr = ev;
        end
        e_vec[j].jen = 1'b1;
        for (int c = t + 1; c <= j; c++) e_vec[c].stall = 1'b1;
        free_at = j + 1;
    endtask

    task automatic drive(input int c);
        @(negedge clk);
        bus.trap_req_i = s_req[c];
        bus.trap_pc_i  = s_pc[c];
        a7             = s_a7[c];
        pipe_idle      = s_idle[c];
        mtvec          = s_mtvec[c];
        mepc           = s_mepc[c];
        mstatus        = s_mst[c];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.trap_req_i = 2'b00;
        bus.trap_pc_i  = '0;
        pipe_idle = 1'b0;
        mtvec = '0; mepc = '0; mstatus = '0; a7 = '0;
`ifdef TRAP_CTRL_TIMER_INTR_EN
        irq_pc = '0; tcmp_we = 1'b0; tcmp_wdata = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        if (obs() !== out_t'(0)) begin
            n_bad++;
            $display("FAIL reset_hold got=%h exp=0", obs());
        end
        n_cmp++;
`ifdef TRAP_CTRL_TIMER_INTR_EN
        if (mtime !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mtime got=%h exp=0", mtime);
        end
        n_cmp++;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (obs() !== out_t'(0)) begin
            n_bad++;
            $display("FAIL reset_release got=%h exp=0", obs());
        end
        n_cmp++;
    endtask

    task automatic test_ecall();
        int t;
        clear_plan();
        add_txn(1, 2'b01, 64'h8000_0010, 64'd11, 64'h8000_0100,
                rnd64(), 64'h8, 0, t);
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL ecall cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_mret();
        int t;
        clear_plan();
        add_txn(1, 2'b10, rnd64(), rnd64(), rnd64(),
                64'h8000_0014, 64'h80, 0, t);
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL mret cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_drain();
        int t;
        clear_plan();
        add_txn(2, 2'b01, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 3, t);
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL drain cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        int t, t2, t3;
        clear_plan();
        add_txn(1, 2'b01, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, t);
        add_txn(t + 5, 2'b10, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 1, t2);
        add_txn(t2 + 1, 2'b01, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, t3);
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_plan();
        add_txn(1, 2'b01, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, t);
        for (int c = 0; c <= 4; c++) begin
            drive(c);
            if (c == 4) rst = 1'b1;
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
        clear_plan();
        add_txn(4, 2'b01, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, t);
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (c == 0) rst = 1'b0;
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        int t;
        clear_plan();
        t = 0;
        for (int k = 0; k < 40; k++) begin
            add_txn(t + $urandom_range(1, 8),
                    ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                    rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                    $urandom_range(0, 3), t);
        end
        for (int c = 0; c < free_at + 3; c++) begin
            drive(c);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
        end
    endtask

`ifdef TRAP_CTRL_TIMER_INTR_EN
    task automatic test_timer();
        clear_plan();
        irq_pc     = 64'h8000_0200;
        tcmp_wdata = 64'd20;
        tcmp_we    = 1'b0;
        for (int c = 0; c < N; c++) begin
            s_mst[c]   = (c <= 24) ? 64'h8 : 64'h1880;
            s_mtvec[c] = 64'h8000_0100;
        end
        for (int c = 20; c <= 26; c++) begin
            s_req[c] = 2'b01;
            s_pc[c]  = 64'h8000_0040;
            s_a7[c]  = 64'd11;
        end
        s_idle[21] = 1'b1;
        s_idle[27] = 1'b1;
        for (int c = 21; c <= 25; c++) e_vec[c].stall = 1'b1;
        e_vec[22] = '{1'b0, 1'b1, 1'b1, 12'h341, 64'h8000_0200, 1'b0, 64'h0};
        e_vec[23] = '{1'b0, 1'b1, 1'b1, 12'h342,
                      64'h8000_0000_0000_0007, 1'b0, 64'h0};
        e_vec[24] = '{1'b0, 1'b1, 1'b1, 12'h300, enter_model(64'h8), 1'b0, 64'h0};
        e_vec[25] = '{1'b0, 1'b1, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0100};
        e_vec[26].ack = 1'b1;
        for (int c = 27; c <= 31; c++) e_vec[c].stall = 1'b1;
        e_vec[28] = '{1'b0, 1'b1, 1'b1, 12'h341, 64'h8000_0040, 1'b0, 64'h0};
        e_vec[29] = '{1'b0, 1'b1, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0};
        e_vec[30] = '{1'b0, 1'b1, 1'b1, 12'h300, enter_model(64'h1880), 1'b0, 64'h0};
        e_vec[31] = '{1'b0, 1'b1, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0100};
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 35; c++) begin
            drive(c);
            tcmp_we = (c == 0);
            if (obs() !== e_vec[c]) begin
                n_bad++;
                $display("FAIL timer cyc=%0d got=%h exp=%h", c, obs(), e_vec[c]);
            end
            n_cmp++;
            if (c == 10) begin
                if (mtime !== 64'd10) begin
                    n_bad++;
                    $display("FAIL mtime got=%0d exp=10", mtime);
                end
                n_cmp++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef TRAP_CTRL_TIMER_INTR_EN
        test_timer();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
